current_monitor: RTL and testbench
==================================

Name: current_monitor

Overview:
- Digitises motor-A current from the ADC sample stream and produces the Over1 / Under750 level flags consumed by the motor power-stop logic.
- Runs a 2^AVG_LOG2-sample running average, compares it against the 1 A and 750 mA codes, and debounces each flag.
- Outputs the average for the SSEG display path.
- Sits between the XADC wrapper and the motor control block, on the same CLK.

Parameters:
- ADC_W, 12: ADC sample width.
- AVG_LOG2, 3: log2 of the averaging window (window = 8).
- OVER_THRESH, 1241: code for 1 A; Over1 condition is avg > OVER_THRESH.
- UNDER_THRESH, 931: code for 750 mA; Under750 condition is avg < UNDER_THRESH. Must be < OVER_THRESH.
- OVER_CNT, 4: consecutive over-averages required to assert Over1 (≥1).
- UNDER_CNT, 16: consecutive under-averages required to assert Under750 (≥1).
- TIMEOUT_CYC, 100000: watchdog limit in CLK cycles (SAMPLE_TIMEOUT_EN only).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- ADC_DATA  in  ADC_W  current-sense sample.
- ADC_VALID  in  1  one-cycle strobe; ADC_DATA is valid when high; may be high every cycle.
- Over1  out  1  debounced over-current flag (1 A).
- Under750  out  1  debounced under-current flag (750 mA).
- AVG  out  ADC_W  latest running average.
- AVG_VALID  out  1  one-cycle pulse when AVG updates.
- ADC_FAULT  out  1  watchdog fault; tied 0 when SAMPLE_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async, RST high):
  - Buffer entries, sum, counters and AVG = 0.
  - Over1 = 0, Under750 = 0, AVG_VALID = 0, ADC_FAULT = 0.
  - FSM = WARMUP, warm count = 0.
  - Release is synchronous to CLK.
- Stage 1, edge E0 where ADC_VALID = 1:
  - Write ADC_DATA to the circular buffer at the write pointer; pointer wraps modulo 2^AVG_LOG2.
  - sum <= sum + ADC_DATA - oldest entry.
  - sum width is ADC_W + AVG_LOG2, so it never overflows.
- Stage 2, edge E1 = E0 + 1:
  - AVG <= sum >> AVG_LOG2 (truncating).
  - Flags and counters update from the same value.
  - AVG_VALID is high for the one cycle following E1.
  - Back-to-back samples pipeline with no stalls; latency is 2 edges from sample to flags.
- FSM states: WARMUP, RUN, FAULT.
- WARMUP:
  - Counts accepted samples; moves to RUN once 2^AVG_LOG2 samples have been accepted.
  - No AVG_VALID; debounce counters held at 0; Over1 = 0, Under750 = 0.
  - The first AVG_VALID comes from the 2^AVG_LOG2-th sample.
- RUN, per average:
  - If avg > OVER_THRESH: over_cnt increments, saturating at OVER_CNT; Over1 sets when over_cnt reaches OVER_CNT.
  - Otherwise: over_cnt = 0 and Over1 = 0, effective the same edge.
  - Under750 and under_cnt behave identically using avg < UNDER_THRESH and UNDER_CNT.
  - avg == threshold counts as "not over" and "not under". Both flags can never be 1 together.
- Flags hold between averages. No hysteresis here; hysteresis lives downstream.
- RST asserted mid-pipeline discards in-flight samples; no AVG_VALID is emitted for them.

Optional Feature:
- Macro: SAMPLE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every ADC_VALID.
  - If it reaches TIMEOUT_CYC in RUN or WARMUP, FSM goes to FAULT.
  - In FAULT: Over1 = 1, Under750 = 0, ADC_FAULT = 1, debounce counters cleared. This fail-safes the motor off.
  - The next ADC_VALID is accepted normally and moves the FSM to WARMUP. ADC_FAULT and Over1 clear at that edge; buffer and sum are retained; warm count restarts from 1.
- Undefined:
  - No counter, FAULT is unreachable, ADC_FAULT is constant 0.

Decomposition:
- Package motor_pkg:
  - Monitor state enum (WARMUP, RUN, FAULT).
  - Default threshold codes (1 A, 750 mA).
  - ADC_W default.
- Sub-module sample_window: circular buffer, write pointer and running sum (stage 1).
- current_monitor keeps the FSM, the debounce logic, the stage-2 registers and the watchdog.

Test Plan:
- Reset, then 8 samples of 1000 one per cycle -> first AVG_VALID 2 cycles after the 8th sample; AVG = 1000; Over1 = 0; Under750 = 0.
- Steady 1300 after warmup -> AVG reaches 1300; Over1 rises on the 4th consecutive average > 1241; Under750 = 0 throughout.
- Steady 900 -> Under750 rises on the 16th consecutive average < 931; one 1000 sample resets the count and drops Under750 on that edge.
- Averages exactly 1241 and exactly 931 -> neither flag set; counters stay 0.
- RST pulse mid-stream with samples in flight -> all outputs 0 immediately; WARMUP restarts; no stray AVG_VALID.
- SAMPLE_TIMEOUT_EN with TIMEOUT_CYC = 50, ADC_VALID stopped -> at cycle 50: ADC_FAULT = 1, Over1 = 1. Next sample -> both clear; AVG_VALID resumes after 8 samples.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and default constants for the motor current monitor slice.
//   mon_state_e      : monitor FSM states (WARMUP, RUN, FAULT)
//   ADC_W_DEF        : default ADC sample width
//   OVER/UNDER_*_DEF : default 1 A and 750 mA ADC codes
//   cnt_w()          : bit width needed to hold 0..max_val
package motor_pkg;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      RUN    = 2'd1,
      FAULT  = 2'd2
   } mon_state_e;

   localparam int unsigned ADC_W_DEF        = 12;
   localparam int unsigned OVER_THRESH_DEF  = 1241;
   localparam int unsigned UNDER_THRESH_DEF = 931;

   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/current_monitor_if.sv
// ADC sample stream in, level flags and average out.
//   master : XADC-side producer / motor-control consumer view
//   slave  : current_monitor view
interface current_monitor_if
   import motor_pkg::*;
#(
   parameter int unsigned ADC_W = ADC_W_DEF
);
   logic [ADC_W-1:0] ADC_DATA;
   logic             ADC_VALID;
   logic             Over1;
   logic             Under750;
   logic [ADC_W-1:0] AVG;
   logic             AVG_VALID;
   logic             ADC_FAULT;

   modport master (
      output ADC_DATA, ADC_VALID,
      input  Over1, Under750, AVG, AVG_VALID, ADC_FAULT
   );

   modport slave (
      input  ADC_DATA, ADC_VALID,
      output Over1, Under750, AVG, AVG_VALID, ADC_FAULT
   );
endinterface

// File: rtl/sample_window.sv
// Stage 1: circular sample buffer and running sum over 2^AVG_LOG2 samples.
//   clk, rst  : clock, async active-high reset
//   in_valid  : accept in_data this edge
//   in_data   : ADC sample
//   sum       : registered sum of the last 2^AVG_LOG2 accepted samples
module sample_window
   import motor_pkg::*;
#(
   parameter int unsigned ADC_W    = ADC_W_DEF,
   parameter int unsigned AVG_LOG2 = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [ADC_W-1:0]          in_data,
   output logic [ADC_W+AVG_LOG2-1:0] sum
);
   localparam int unsigned WIN   = 1 << AVG_LOG2;
   localparam int unsigned SUM_W = ADC_W + AVG_LOG2;

   logic [ADC_W-1:0]    win_q [WIN];
   logic [ADC_W-1:0]    win_d [WIN];
   logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [SUM_W-1:0]    sum_q, sum_d;

   // Replace the oldest entry; the sum tracks the window by add-new/drop-old.
   always_comb begin
      win_d    = win_q;
      wr_ptr_d = wr_ptr_q;
      sum_d    = sum_q;
      if (in_valid) begin
         win_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + AVG_LOG2'(1);
         sum_d           = sum_q + SUM_W'(in_data) - SUM_W'(win_q[wr_ptr_q]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(WIN); i++) win_q[i] <= '0;
         wr_ptr_q <= '0;
         sum_q    <= '0;
      end else begin
         win_q    <= win_d;
         wr_ptr_q <= wr_ptr_d;
         sum_q    <= sum_d;
      end
   end

   assign sum = sum_q;
endmodule

// File: rtl/current_monitor.sv
// Motor-A current monitor: running average, debounced Over1/Under750 flags.
//   CLK, RST : clock, async active-high reset
//   bus      : current_monitor_if.slave (ADC_DATA/ADC_VALID in;
//              Over1, Under750, AVG, AVG_VALID, ADC_FAULT out)
// Optional: define SAMPLE_TIMEOUT_EN to enable the sample watchdog and FAULT
// state; otherwise ADC_FAULT is constant 0.
module current_monitor
   import motor_pkg::*;
#(
   parameter int unsigned ADC_W        = ADC_W_DEF,
   parameter int unsigned AVG_LOG2     = 3,
   parameter int unsigned OVER_THRESH  = OVER_THRESH_DEF,
   parameter int unsigned UNDER_THRESH = UNDER_THRESH_DEF,
   parameter int unsigned OVER_CNT     = 4,
   parameter int unsigned UNDER_CNT    = 16,
   parameter int unsigned TIMEOUT_CYC  = 100000
) (
   input logic              CLK,
   input logic              RST,
   current_monitor_if.slave bus
);
   localparam int unsigned WIN    = 1 << AVG_LOG2;
   localparam int unsigned SUM_W  = ADC_W + AVG_LOG2;
   localparam int unsigned WARM_W = AVG_LOG2 + 1;
   localparam int unsigned OC_W   = cnt_w(OVER_CNT);
   localparam int unsigned UC_W   = cnt_w(UNDER_CNT);

   mon_state_e        state_q, state_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [OC_W-1:0]   over_cnt_q, over_cnt_d;
   logic [UC_W-1:0]   under_cnt_q, under_cnt_d;
   logic              over1_q, over1_d;
   logic              under750_q, under750_d;
   logic [ADC_W-1:0]  avg_q, avg_d;
   logic              avg_valid_q, avg_valid_d;
   logic              s1_valid_q, s1_valid_d;
   logic [SUM_W-1:0]  sum_c;
   logic [ADC_W-1:0]  avg_c;
`ifdef SAMPLE_TIMEOUT_EN
   localparam int unsigned WD_W = cnt_w(TIMEOUT_CYC);
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              fault_q, fault_d;
`else
   logic              unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

   sample_window #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_window (
      .clk      (CLK),
      .rst      (RST),
      .in_valid (bus.ADC_VALID),
      .in_data  (bus.ADC_DATA),
      .sum      (sum_c)
   );

   assign avg_c = ADC_W'(sum_c >> AVG_LOG2);

   always_comb begin
      state_d     = state_q;
      warm_d      = warm_q;
      over_cnt_d  = over_cnt_q;
      under_cnt_d = under_cnt_q;
      over1_d     = over1_q;
      under750_d  = under750_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      s1_valid_d  = bus.ADC_VALID;
`ifdef SAMPLE_TIMEOUT_EN
      wd_d        = wd_q;
      fault_d     = fault_q;
`endif

      // Stage 2: the sum registered last edge becomes the published average.
      if (s1_valid_q && (state_q == RUN)) begin
         avg_d       = avg_c;
         avg_valid_d = 1'b1;
         if (32'(avg_c) > OVER_THRESH) begin
            if (over_cnt_q != OC_W'(OVER_CNT)) over_cnt_d = over_cnt_q + OC_W'(1);
            over1_d = (over_cnt_d == OC_W'(OVER_CNT));
         end else begin
            over_cnt_d = '0;
            over1_d    = 1'b0;
         end
         if (32'(avg_c) < UNDER_THRESH) begin
            if (under_cnt_q != UC_W'(UNDER_CNT)) under_cnt_d = under_cnt_q + UC_W'(1);
            under750_d = (under_cnt_d == UC_W'(UNDER_CNT));
         end else begin
            under_cnt_d = '0;
            under750_d  = 1'b0;
         end
      end

      // State progression on accepted samples; the WIN-th sample enters RUN
      // on its own edge so its average is published.
      case (state_q)
         WARMUP: begin
            if (bus.ADC_VALID) begin
               if (warm_q == WARM_W'(WIN - 1)) begin
                  state_d = RUN;
                  warm_d  = '0;
               end else begin
                  warm_d = warm_q + WARM_W'(1);
               end
            end
         end
         RUN: begin
         end
`ifdef SAMPLE_TIMEOUT_EN
         FAULT: begin
            if (bus.ADC_VALID) begin
               state_d = WARMUP;
               warm_d  = WARM_W'(1);
               fault_d = 1'b0;
               over1_d = 1'b0;
            end
         end
`endif
         default: state_d = WARMUP;
      endcase

`ifdef SAMPLE_TIMEOUT_EN
      // Watchdog: a stalled ADC forces Over1 so the motor is stopped.
      if (bus.ADC_VALID) begin
         wd_d = '0;
      end else if (state_q != FAULT) begin
         if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d     = FAULT;
            fault_d     = 1'b1;
            over1_d     = 1'b1;
            under750_d  = 1'b0;
            over_cnt_d  = '0;
            under_cnt_d = '0;
            wd_d        = '0;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= WARMUP;
         warm_q      <= '0;
         over_cnt_q  <= '0;
         under_cnt_q <= '0;
         over1_q     <= 1'b0;
         under750_q  <= 1'b0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
`ifdef SAMPLE_TIMEOUT_EN
         wd_q        <= '0;
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         over_cnt_q  <= over_cnt_d;
         under_cnt_q <= under_cnt_d;
         over1_q     <= over1_d;
         under750_q  <= under750_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         s1_valid_q  <= s1_valid_d;
`ifdef SAMPLE_TIMEOUT_EN
         wd_q        <= wd_d;
         fault_q     <= fault_d;
`endif
      end
   end

   assign bus.Over1     = over1_q;
   assign bus.Under750  = under750_q;
   assign bus.AVG       = avg_q;
   assign bus.AVG_VALID = avg_valid_q;
`ifdef SAMPLE_TIMEOUT_EN
   assign bus.ADC_FAULT = fault_q;
`else
   assign bus.ADC_FAULT = 1'b0;
`endif
endmodule

// File: tb/tb_current_monitor.sv
// Testbench for current_monitor: reference model of the windowed average and
// debounce rules, a warm-up vector table, threshold/corner sequences, and a
// randomized stream. Define SAMPLE_TIMEOUT_EN to also exercise the watchdog.
module tb_current_monitor;
   import motor_pkg::*;

   localparam int unsigned ADC_W = 12;
   localparam int WIN     = 8;
   localparam int OVER_T  = 1241;
   localparam int UNDER_T = 931;
   localparam int OVER_N  = 4;
   localparam int UNDER_N = 16;
`ifdef SAMPLE_TIMEOUT_EN
   localparam int TO_CYC  = 50;
`else
   localparam int TO_CYC  = 100000;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   current_monitor_if #(.ADC_W(ADC_W)) bus ();

   current_monitor #(
      .ADC_W        (ADC_W),
      .AVG_LOG2     (3),
      .OVER_THRESH  (OVER_T),
      .UNDER_THRESH (UNDER_T),
      .OVER_CNT     (OVER_N),
      .UNDER_CNT    (UNDER_N),
      .TIMEOUT_CYC  (TO_CYC)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: history of accepted samples (zero-filled at reset),
   // the average of the last WIN of them, and run lengths of over/under
   // averages since the last non-over/non-under average.
   int hist[$];
   int since_warm, pend_avg, over_run, under_run, m_avg;
   bit pend_v, pend_emit, m_av, m_over, m_under, m_fault;
`ifdef SAMPLE_TIMEOUT_EN
   int idle;
`endif

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < WIN; i++) hist.push_back(0);
      since_warm = 0; pend_avg = 0; over_run = 0; under_run = 0; m_avg = 0;
      pend_v = 0; pend_emit = 0; m_av = 0; m_over = 0; m_under = 0; m_fault = 0;
`ifdef SAMPLE_TIMEOUT_EN
      idle = 0;
`endif
   endfunction

   function automatic void model_edge(input bit v, input int d);
      int s;
      m_av = 0;
      if (pend_v && pend_emit) begin
         m_av  = 1;
         m_avg = pend_avg;
         over_run  = (pend_avg > OVER_T)  ? over_run + 1  : 0;
         under_run = (pend_avg < UNDER_T) ? under_run + 1 : 0;
         m_over  = (over_run  >= OVER_N);
         m_under = (under_run >= UNDER_N);
      end
      pend_v = 0;
      if (v) begin
         hist.push_back(d);
         void'(hist.pop_front());
         s = 0;
         foreach (hist[i]) s += hist[i];
         pend_avg = s / WIN;
         if (m_fault) begin
            m_fault = 0; m_over = 0; since_warm = 1;
         end else begin
            since_warm++;
         end
         pend_emit = (since_warm >= WIN);
         pend_v = 1;
`ifdef SAMPLE_TIMEOUT_EN
         idle = 0;
      end else if (!m_fault) begin
         idle++;
         if (idle == TO_CYC) begin
            m_fault = 1; m_over = 1; m_under = 0;
            over_run = 0; under_run = 0; idle = 0;
         end
`endif
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("avg_valid", 32'(bus.AVG_VALID), 32'(m_av));
      chk("avg",       32'(bus.AVG),       32'(m_avg));
      chk("over1",     32'(bus.Over1),     32'(m_over));
      chk("under750",  32'(bus.Under750),  32'(m_under));
      chk("adc_fault", 32'(bus.ADC_FAULT), 32'(m_fault));
      chk("flags_exclusive", 32'(bus.Over1 & bus.Under750), 32'(0));
   endtask

   task automatic step(input bit v, input int d);
      bus.ADC_VALID = v;
      bus.ADC_DATA  = ADC_W'(d);
      @(posedge clk);
      model_edge(v, d);
      #1;
      check_model();
   endtask

   // Feed n samples of one value then one idle cycle; report the sample
   // index (1-based) whose average first raised/dropped each flag, or -1.
   task automatic feed(input int val, input int n,
                       output int over_rise, output int under_rise, output int under_fall);
      logic po, pu;
      over_rise = -1; under_rise = -1; under_fall = -1;
      po = bus.Over1; pu = bus.Under750;
      for (int j = 1; j <= n + 1; j++) begin
         step(j <= n, (j <= n) ? val : 0);
         if (!po && bus.Over1 && over_rise < 0) over_rise = j - 1;
         if (!pu && bus.Under750 && under_rise < 0) under_rise = j - 1;
         if (pu && !bus.Under750 && under_fall < 0) under_fall = j - 1;
         po = bus.Over1; pu = bus.Under750;
      end
   endtask

   typedef struct {
      bit   v;
      int   d;
      bit   e_av;
      int   e_avg;
      bit   e_over;
      bit   e_under;
   } vec_t;

   vec_t tbl[10];
   int orise, urise, ufall, nav, base;

   initial begin
      rst = 1'b1;
      bus.ADC_VALID = 1'b0;
      bus.ADC_DATA  = '0;
      model_reset();
      #12;
      chk("rst_avg_valid", 32'(bus.AVG_VALID), 0);
      chk("rst_avg",       32'(bus.AVG), 0);
      chk("rst_over1",     32'(bus.Over1), 0);
      chk("rst_under750",  32'(bus.Under750), 0);
      chk("rst_adc_fault", 32'(bus.ADC_FAULT), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Warm-up: first AVG_VALID appears two edges after the 8th sample.
      for (int i = 0; i < 8; i++) tbl[i] = '{1, 1000, 0, 0, 0, 0};
      tbl[8] = '{0, 0, 1, 1000, 0, 0};
      tbl[9] = '{0, 0, 0, 1000, 0, 0};
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_avg_valid", i), 32'(bus.AVG_VALID), 32'(tbl[i].e_av));
         chk($sformatf("tbl%0d_avg", i),       32'(bus.AVG),       32'(tbl[i].e_avg));
         chk($sformatf("tbl%0d_over1", i),     32'(bus.Over1),     32'(tbl[i].e_over));
         chk($sformatf("tbl%0d_under750", i),  32'(bus.Under750),  32'(tbl[i].e_under));
      end

      // 1300 into a 1000 window: 7th average is the first above 1241.
      feed(1300, 20, orise, urise, ufall);
      chk("over1_rise_idx_1300", 32'(orise), 32'(10));
      chk("under_never_1300", 32'(urise), 32'(-1));
      chk("avg_steady_1300", 32'(bus.AVG), 32'(1300));

      // 900 into a 1300 window: 8th average first below 931, 16th asserts.
      feed(900, 30, orise, urise, ufall);
      chk("under_rise_idx_900", 32'(urise), 32'(23));
      // Third 1000 sample lifts the average to 937 and drops Under750.
      feed(1000, 10, orise, urise, ufall);
      chk("under_fall_idx_1000", 32'(ufall), 32'(3));

      // Exactly at thresholds: neither flag, and no counting toward them.
      feed(1241, 12, orise, urise, ufall);
      chk("avg_eq_over", 32'(bus.AVG), 32'(1241));
      chk("over_eq_thresh", 32'(bus.Over1), 0);
      feed(1300, 8, orise, urise, ufall);
      chk("over_rise_after_eq", 32'(orise), 32'(4));
      feed(931, 12, orise, urise, ufall);
      chk("avg_eq_under", 32'(bus.AVG), 32'(931));
      chk("under_eq_thresh", 32'(bus.Under750), 0);
      feed(900, 20, orise, urise, ufall);
      chk("under_rise_after_eq", 32'(urise), 32'(16));

      // Reset mid-stream with samples in flight and Over1 set.
      feed(1300, 16, orise, urise, ufall);
      step(1, 1300);
      step(1, 1300);
      rst = 1'b1;
      #1;
      chk("midrst_avg_valid", 32'(bus.AVG_VALID), 0);
      chk("midrst_avg",       32'(bus.AVG), 0);
      chk("midrst_over1",     32'(bus.Over1), 0);
      chk("midrst_under750",  32'(bus.Under750), 0);
      chk("midrst_adc_fault", 32'(bus.ADC_FAULT), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step(0, 0);
      chk("midrst_no_stray_valid", 32'(bus.AVG_VALID), 0);
      nav = 0;
      for (int i = 0; i < 10; i++) begin
         step(i < 8, 1100);
         nav += int'(bus.AVG_VALID);
      end
      chk("rewarm_valid_count", 32'(nav), 32'(1));

      // Randomized phases around each threshold.
      for (int p = 0; p < 15; p++) begin
         case ($urandom_range(0, 2))
            0:       base = 900;
            1:       base = 1000;
            default: base = 1290;
         endcase
         for (int i = 0; i < 40; i++)
            step($urandom_range(0, 9) < 8, base + int'($urandom_range(0, 60)) - 30);
      end

`ifdef SAMPLE_TIMEOUT_EN
      // Watchdog: 50 idle cycles fault; next sample clears and re-warms.
      step(1, 1000);
      for (int i = 0; i < TO_CYC - 1; i++) step(0, 0);
      chk("wd_before_timeout", 32'(bus.ADC_FAULT), 0);
      step(0, 0);
      chk("wd_fault_set", 32'(bus.ADC_FAULT), 1);
      chk("wd_over1_set", 32'(bus.Over1), 1);
      nav = 0;
      for (int i = 0; i < 10; i++) begin
         step(i < 8, 1000);
         if (i == 0) begin
            chk("wd_fault_clear", 32'(bus.ADC_FAULT), 0);
            chk("wd_over1_clear", 32'(bus.Over1), 0);
         end
         nav += int'(bus.AVG_VALID);
      end
      chk("wd_rewarm_valid_count", 32'(nav), 32'(1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
